// File: rtl/ddr_rd_burst_responder.sv
// Responder for the rd_burst_* DDR read interface. One request is turned
// into one or more AXI4 INCR read bursts (split at MAX_BURST beats and at
// 4 KB pages), one burst outstanding at a time, and the returned beats are
// forwarded one cycle after acceptance.
//
// Handshakes: an AXI transfer happens on a rising edge where both valid and
// ready are high; once arvalid is raised, the AR fields stay stable until
// arready is seen. rready is high only in R. Beats are always accepted there,
// because the requester guarantees buffer space for the whole burst.
module ddr_rd_burst_responder #(
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    ADDR_SIZE   = 32,
  parameter int                    LEN_WIDTH   = 10,
  parameter int                    AXI_ADDR_W  = 32,
  parameter int                    MAX_BURST   = 64,
  parameter logic [AXI_ADDR_W-1:0] ADDR_OFFSET = '0
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic                  rd_burst_req,
  input  logic [ADDR_SIZE-1:0]  rd_burst_addr,
  input  logic [LEN_WIDTH-1:0]  rd_burst_len,
  output logic [DATA_WIDTH-1:0] rd_burst_data,
  output logic                  rd_burst_valid,
  output logic                  rd_burst_finish,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  localparam int BPB    = DATA_WIDTH / 8;
  localparam int ARSIZE = $clog2(BPB);
  localparam int MW     = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [AXI_ADDR_W-1:0] baddr_q, baddr_d;
  logic [8:0]            chunk_q, chunk_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  finish_q, finish_d;
  logic                  err_q, err_d;

  logic [12:0]           page_bytes;
  logic [MW-1:0]         page_beats;
  logic [MW-1:0]         chunk_full;
  logic [8:0]            chunk_c;

  // Size of the next AXI burst: remaining beats, capped by MAX_BURST and by
  // the beats left before the next 4 KB page boundary.
  always_comb begin
    page_bytes = 13'd4096 - {1'b0, baddr_q[11:0]};
    page_beats = MW'(page_bytes >> ARSIZE);
    chunk_full = MW'(rem_q);
    if (chunk_full > MW'(MAX_BURST)) chunk_full = MW'(MAX_BURST);
    if (chunk_full > page_beats)     chunk_full = page_beats;
    chunk_c = 9'(chunk_full);
  end

  // Next-state, request bookkeeping and registered beat/finish/err outputs.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    baddr_d    = baddr_q;
    chunk_d    = chunk_q;
    beat_cnt_d = beat_cnt_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    finish_d   = 1'b0;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_burst_req) begin
          rem_d   = rd_burst_len;
          baddr_d = ADDR_OFFSET + (AXI_ADDR_W'(rd_burst_addr) << ARSIZE);
          if (rd_burst_len == '0) begin
            state_d  = ST_DONE;
            finish_d = 1'b1;
          end else begin
            state_d = ST_AR;
          end
        end
      end
      ST_AR: begin
        if (m_axi_arready) begin
          chunk_d    = chunk_c;
          beat_cnt_d = chunk_c;
          state_d    = ST_R;
        end
      end
      ST_R: begin
        if (m_axi_rvalid) begin
          valid_d    = 1'b1;
          data_d     = m_axi_rdata;
          beat_cnt_d = beat_cnt_q - 9'd1;
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
          // The beat counter decides where the burst ends; rlast is only
          // cross-checked against it.
          if (m_axi_rlast != (beat_cnt_q == 9'd1)) err_d = 1'b1;
          if (beat_cnt_q == 9'd1) begin
            rem_d   = rem_q - LEN_WIDTH'(chunk_q);
            baddr_d = baddr_q + (AXI_ADDR_W'(chunk_q) << ARSIZE);
            if (rem_d == '0) begin
              state_d  = ST_DONE;
              finish_d = 1'b1;
            end else begin
              state_d = ST_AR;
            end
          end
        end
      end
      ST_DONE: begin
        // Spend one cycle here so the still-high req is not re-accepted.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      baddr_q    <= '0;
      chunk_q    <= '0;
      beat_cnt_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      finish_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      baddr_q    <= baddr_d;
      chunk_q    <= chunk_d;
      beat_cnt_q <= beat_cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      finish_q   <= finish_d;
      err_q      <= err_d;
    end
  end

  // AR fields are driven only while requesting so they read 0 elsewhere.
  always_comb begin
    m_axi_arvalid = (state_q == ST_AR);
    m_axi_araddr  = m_axi_arvalid ? baddr_q : '0;
    m_axi_arlen   = m_axi_arvalid ? 8'(chunk_c - 9'd1) : 8'd0;
    m_axi_rready  = (state_q == ST_R);
  end

  assign m_axi_arsize    = 3'(ARSIZE);
  assign m_axi_arburst   = 2'b01;
  assign rd_burst_data   = data_q;
  assign rd_burst_valid  = valid_q;
  assign rd_burst_finish = finish_q;
  assign err             = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_ddr_rd_burst_responder.sv
// Bench for ddr_rd_burst_responder: a behavioural AXI read slave whose data
// is a function of the byte address, plus a request-level model giving the
// expected AR sequence and beat stream for every request.
module tb_ddr_rd_burst_responder;

  localparam logic [31:0] ADDR_OFF = 32'd0;

  // ---------------- clock / reset ----------------
  logic s_clk = 1'b0;
  logic s_rst;
  always #5 s_clk = ~s_clk;

  logic        rd_burst_req;
  logic [31:0] rd_burst_addr;
  logic [9:0]  rd_burst_len;
  logic [63:0] rd_burst_data;
  logic        rd_burst_valid, rd_burst_finish;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        err;
  logic [1:0]  dbg_state;

  ddr_rd_burst_responder #(
    .DATA_WIDTH(64), .ADDR_SIZE(32), .LEN_WIDTH(10), .AXI_ADDR_W(32),
    .MAX_BURST(64), .ADDR_OFFSET(ADDR_OFF)
  ) dut (
    .s_clk(s_clk), .s_rst(s_rst),
    .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
    .rd_burst_data(rd_burst_data), .rd_burst_valid(rd_burst_valid), .rd_burst_finish(rd_burst_finish),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [63:0] exp_q[$];
  logic [39:0] ar_exp_q[$];
  int   n_beats, n_fin, cur_len, first_evt_cyc;
  int   last_fin_cyc = -100;
  int   last_idle    = 1;
  logic exp_err      = 1'b0;

  // slave knobs / state
  int          r_pending = 0;
  logic [31:0] r_addr    = '0;
  int          g_beat    = 0;
  int          ar_wait   = -1;
  int          stall_set = 0;
  int          slverr_beat = -1;
  int          rlast_bad_beat = -1;
  bit          gap_rvalid = 1'b0;

  function automatic logic [63:0] beat_data(input logic [31:0] a);
    return {a, a ^ 32'hA5A5_5A5A};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of bench activity: observe outputs, then drive the slave.
  task automatic step();
    @(negedge s_clk);
    cyc++;
    if (rd_burst_valid) begin
      n_beats++;
      if (exp_q.size() == 0) chk("extra_beat", 64'(1), 64'(0));
      else                   chk("beat_data", rd_burst_data, exp_q.pop_front());
    end
    if (rd_burst_finish) begin
      n_fin++;
      chk("finish_with_last", 64'(rd_burst_valid), 64'(cur_len != 0));
      chk("finish_beats", 64'(n_beats), 64'(cur_len));
      if (first_evt_cyc < 0) first_evt_cyc = cyc;
      last_fin_cyc = cyc;
    end
    if (m_axi_arvalid) begin
      if (first_evt_cyc < 0) first_evt_cyc = cyc;
      if (ar_exp_q.size() == 0) chk("ar_unexpected", 64'(1), 64'(0));
      else chk("ar_addr_len", 64'({m_axi_araddr, m_axi_arlen}), 64'(ar_exp_q[0]));
      chk("ar_size_burst", 64'({m_axi_arsize, m_axi_arburst}), 64'(5'b01101));
      chk("rready_in_ar", 64'(m_axi_rready), 64'(0));
    end
    // R channel
    if (r_pending > 0) begin
      m_axi_rvalid = gap_rvalid ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axi_rdata  = beat_data(r_addr);
      m_axi_rresp  = (g_beat == slverr_beat) ? 2'b10 : 2'b00;
      m_axi_rlast  = (r_pending == 1) || (g_beat == rlast_bad_beat);
      if (m_axi_rvalid && m_axi_rready) begin
        r_pending--;
        r_addr = r_addr + 32'd8;
        g_beat++;
      end
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
    end
    // AR channel
    m_axi_arready = 1'b0;
    if (r_pending == 0 && m_axi_arvalid) begin
      if (ar_wait < 0) ar_wait = stall_set;
      if (ar_wait == 0) begin
        m_axi_arready = 1'b1;
        r_pending = int'(m_axi_arlen) + 1;
        r_addr    = m_axi_araddr;
        if (ar_exp_q.size() > 0) void'(ar_exp_q.pop_front());
        ar_wait = -1;
      end else begin
        ar_wait--;
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"},  64'(rd_burst_valid), 64'(0));
    chk({tag, "_finish"}, 64'(rd_burst_finish), 64'(0));
    chk({tag, "_data"},   rd_burst_data, 64'(0));
    chk({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'(0));
    chk({tag, "_araddr_arlen"}, 64'({m_axi_araddr, m_axi_arlen}), 64'(0));
    chk({tag, "_rready"}, 64'(m_axi_rready), 64'(0));
    chk({tag, "_err"},    64'(err), 64'(0));
    chk({tag, "_arsize_arburst"}, 64'({m_axi_arsize, m_axi_arburst}), 64'(5'b01101));
    chk({tag, "_state"},  64'(dbg_state), 64'(0));
  endtask

  // Request-level model: expected AR list and beat stream.
  task automatic build_model(input logic [31:0] addr, input int len);
    logic [31:0] a;
    int rem, pg, c;
    a   = ADDR_OFF + (addr << 3);
    rem = len;
    while (rem > 0) begin
      pg = (4096 - int'(a[11:0])) / 8;
      c  = rem;
      if (c > 64) c = 64;
      if (c > pg) c = pg;
      ar_exp_q.push_back({a, 8'(c - 1)});
      a   = a + 32'(c * 8);
      rem = rem - c;
    end
    for (int i = 0; i < len; i++)
      exp_q.push_back(beat_data(ADDR_OFF + ((addr + 32'(i)) << 3)));
  endtask

  task automatic do_req(input logic [31:0] addr, input int len, input int stall,
                        input bit gap, input int slv, input int rbad, input int idle);
    int  guard, prev_fin;
    bit  b2b, scrambled;
    build_model(addr, len);
    b2b       = (last_idle == 0);
    prev_fin  = last_fin_cyc;
    cur_len   = len;
    n_beats   = 0;
    n_fin     = 0;
    first_evt_cyc = -1;
    stall_set = stall;
    gap_rvalid = gap;
    slverr_beat = slv;
    rlast_bad_beat = rbad;
    g_beat    = 0;
    if ((slv >= 0 && slv < len) || (rbad >= 0 && rbad < len)) exp_err = 1'b1;
    rd_burst_req  = 1'b1;
    rd_burst_addr = addr;
    rd_burst_len  = 10'(len);
    scrambled = 1'b0;
    guard = 0;
    while (n_fin == 0 && guard < 3000) begin
      step();
      guard++;
      // Inputs are only meaningful at acceptance; disturb them afterwards.
      if (first_evt_cyc >= 0 && !scrambled) begin
        rd_burst_addr = $urandom;
        rd_burst_len  = 10'($urandom);
        scrambled = 1'b1;
      end
    end
    rd_burst_req = 1'b0;
    if (guard >= 3000) chk("timeout", 64'(1), 64'(0));
    if (b2b) chk("b2b_gap", 64'(first_evt_cyc - prev_fin), 64'(2));
    chk("beat_count", 64'(n_beats), 64'(len));
    chk("ar_left", 64'(ar_exp_q.size()), 64'(0));
    chk("err_flag", 64'(err), 64'(exp_err));
    repeat (idle) step();
    if (idle > 0) chk("single_finish", 64'(n_fin), 64'(1));
    last_idle = idle;
  endtask

  task automatic reset_pulse();
    s_rst = 1'b1;
    r_pending = 0; ar_wait = -1;
    m_axi_rvalid = 1'b0; m_axi_arready = 1'b0;
    step();
    s_rst = 1'b0;
    exp_err = 1'b0;
    exp_q.delete(); ar_exp_q.delete();
    check_outputs_zero("rst");
    last_idle = 1;
  endtask

  task automatic reset_mid(input logic [31:0] addr, input int len, input int at_beats);
    int guard;
    build_model(addr, len);
    cur_len = len; n_beats = 0; n_fin = 0; first_evt_cyc = -1;
    stall_set = 1; gap_rvalid = 1'b0; slverr_beat = -1; rlast_bad_beat = -1; g_beat = 0;
    rd_burst_req = 1'b1; rd_burst_addr = addr; rd_burst_len = 10'(len);
    guard = 0;
    while (n_beats < at_beats && guard < 500) begin
      step();
      guard++;
    end
    if (guard >= 500) chk("reset_mid_timeout", 64'(1), 64'(0));
    rd_burst_req = 1'b0;
    reset_pulse();
    repeat (4) step();
    chk("no_finish_after_reset", 64'(n_fin), 64'(0));
    chk("no_beats_after_reset", 64'(n_beats), 64'(at_beats));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] ra;
    int rl, ri;
    s_rst = 1'b1;
    rd_burst_req = 1'b0; rd_burst_addr = '0; rd_burst_len = '0;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    cur_len = 0; n_beats = 0; n_fin = 0; first_evt_cyc = -1;
    repeat (3) step();
    check_outputs_zero("reset");
    s_rst = 1'b0;
    step();

    do_req(32'd48,  8,   0, 1'b0, -1, -1, 2);   // basic single burst
    do_req(32'd508, 8,   0, 1'b0, -1, -1, 2);   // 4 KB split
    do_req(32'd0,   100, 0, 1'b0, -1, -1, 2);   // MAX_BURST split
    do_req(32'd1000, 20, 5, 1'b0, -1, -1, 2);   // AR stall
    do_req(32'd3000, 5,  0, 1'b0, -1, -1, 0);   // back-to-back chain
    do_req(32'd77,   3,  1, 1'b1, -1, -1, 0);
    do_req(32'd200,  0,  0, 1'b0, -1, -1, 0);
    do_req(32'd90,   4,  0, 1'b0, -1, -1, 2);
    do_req(32'd64,   8,  0, 1'b0,  2, -1, 2);   // SLVERR on beat 3
    do_req(32'd16,   6,  0, 1'b0, -1, -1, 2);   // err stays set
    reset_pulse();
    do_req(32'd64,   8,  0, 1'b0, -1,  4, 2);   // early rlast on beat 5
    reset_pulse();
    reset_mid(32'd400, 8, 3);                   // reset during beat 4
    do_req(32'd400,  8,  0, 1'b0, -1, -1, 2);
    do_req(32'd5,    0,  0, 1'b0, -1, -1, 2);   // len 0

    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 1) == 1) ra = 32'($urandom_range(0, 4000));
      else ra = 32'($urandom_range(1, 7) * 512 - $urandom_range(0, 12));
      rl = $urandom_range(0, 150);
      ri = $urandom_range(0, 2);
      do_req(ra, rl, $urandom_range(0, 3), 1'b1, -1, -1, ri);
    end
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_rd_burst_responder.md
# ddr_rd_burst_responder

Responder end of the `rd_burst_*` DDR read interface used by the weight and feature-map loaders. Accepts one burst request (word address plus beat count) and fetches the data over an AXI4 read-master port (AR/R channels) toward the DDR controller. Returns each beat as `rd_burst_data`/`rd_burst_valid` and pulses `rd_burst_finish` on the final beat. Long or 4 KB-crossing requests are split into multiple AXI bursts, with one AXI burst outstanding at a time.

## Interface
Parameters:
- `DATA_WIDTH`, 64: beat width; also the AXI data width.
- `ADDR_SIZE`, 32: width of `rd_burst_addr`, in units of DATA_WIDTH-bit words.
- `LEN_WIDTH`, 10: width of `rd_burst_len`, in beats.
- `AXI_ADDR_W`, 32: AXI byte-address width.
- `MAX_BURST`, 64: maximum beats per AXI burst (1..256).
- `ADDR_OFFSET`, 0: byte base added to every translated address.

Ports:
- `s_clk` in 1: clock. One clock domain.
- `s_rst` in 1: reset, synchronous, active-high.
- `rd_burst_req` in 1: request. Held high by the requester until it sees `rd_burst_finish`.
- `rd_burst_addr` in ADDR_SIZE: start word address.
- `rd_burst_len` in LEN_WIDTH: beat count.
- `rd_burst_data` out DATA_WIDTH: returned beat.
- `rd_burst_valid` out 1: `rd_burst_data` is valid this cycle.
- `rd_burst_finish` out 1: one-cycle pulse marking the request complete.
- `m_axi_araddr` out AXI_ADDR_W, `m_axi_arlen` out 8, `m_axi_arsize` out 3, `m_axi_arburst` out 2, `m_axi_arvalid` out 1, `m_axi_arready` in 1: AXI read-address channel.
- `m_axi_rdata` in DATA_WIDTH, `m_axi_rresp` in 2, `m_axi_rlast` in 1, `m_axi_rvalid` in 1, `m_axi_rready` out 1: AXI read-data channel.
- `err` out 1: sticky error flag. Set on `rresp` != OKAY or on an `rlast` mismatch. Cleared only by `s_rst`.

## Operation
- States: IDLE, AR, R, DONE.
- IDLE: when `rd_burst_req`=1, latch the request and go to AR.
  - `rem` <= `rd_burst_len`.
  - `baddr` <= `ADDR_OFFSET` + `rd_burst_addr`*(DATA_WIDTH/8). Width: AXI_ADDR_W, truncating.
  - If `rd_burst_len`=0, go to DONE instead, with `rd_burst_finish` pulsing.
- AR: chunk `c` = min(`rem`, MAX_BURST, (4096 − `baddr[11:0]`)/(DATA_WIDTH/8)).
  - `m_axi_arvalid`=1, `araddr`=`baddr`, `arlen`=c−1.
  - `arsize`=log2(DATA_WIDTH/8); `arburst`=INCR (2'b01).
  - All AR fields stay stable until `arready`. On the handshake, go to R.
- R: `m_axi_rready`=1, with no backpressure; the requester guarantees buffer space.
  - Each accepted beat decrements `beat_cnt` (loaded with c).
  - On the beat where `beat_cnt`=1:
    - `rem` <= `rem` − c and `baddr` += c*(DATA_WIDTH/8).
    - If the new `rem`=0, go to DONE; otherwise go to AR.
  - Beat counting is authoritative. If `rlast` disagrees with the final-beat position, set `err` and still follow the counter.
- DONE: hold one cycle, then go to IDLE. This ignores the requester's still-high `req` in the cycle it samples `finish`.
- A non-OKAY `rresp` sets `err`; the data is still forwarded.
- Output reset values: all outputs 0, except constant `arsize`/`arburst`. State resets to IDLE and `err` to 0.
- Reset mid-operation: immediate return to IDLE, the partial request is dropped, and no `finish` is issued. Any in-flight AXI burst is abandoned, so the interconnect must be reset together with this block.

## Timing
- Request in IDLE at cycle t: `arvalid` is high at t+1.
- R beat accepted at cycle k: `rd_burst_valid`=1 and `rd_burst_data`=`rdata` at k+1. Both are registered.
- `rd_burst_finish` is asserted in the same cycle as the final `rd_burst_valid`.
  - For len=0: `rd_burst_finish` at t+1 with no valid.
- Between chunks, `arvalid` rises the cycle after the last beat of the previous chunk.
- After `finish`, the earliest next request acceptance is 2 cycles later (DONE, then IDLE sampling).
- `m_axi_rready` is high only in R. It is low in IDLE, AR and DONE.
- `rd_burst_addr`/`rd_burst_len` are sampled only at acceptance. Later changes have no effect.

## Test plan
- Basic burst: addr 48, len 8, DATA_WIDTH 64, OFFSET 0 -> one AR with `araddr`=384, `arlen`=7, `arsize`=3. Eight `rd_burst_valid` beats carrying the R data in order; `finish` coincides with the 8th beat.
- 4 KB split: addr 508, len 8 -> AR `araddr` 4064 `arlen` 3, then AR `araddr` 4096 `arlen` 3. Exactly 8 valid beats and one `finish`.
- MAX_BURST split: len 100 with MAX_BURST 64 -> `arlen` 63, then `arlen` 35 at +512 bytes. 100 beats, `finish` on the 100th.
- AR stall with back-to-back requests:
  - `arready` held low 5 cycles -> `arvalid` and all AR fields stable throughout.
  - A requester that re-raises `req` after `finish` -> each request accepted exactly once, with no duplicate AR.
- Errors:
  - `rresp`=SLVERR on beat 3 -> `err`=1 and stays 1; all beats still forwarded.
  - `rlast` on beat 5 of 8 -> `err`=1; the transfer still completes with 8 beats.
- Reset and len 0:
  - `s_rst` during beat 4 of 8 -> all outputs 0 the next cycle and no `finish`; a new request is then serviced normally.
  - len 0 -> no AR, `finish` only.
